// File: rtl/memset_engine_if.sv
// -----------------------------------------------------------------------------
// memset_engine_if
//   Bundles the job handshake (start/params/busy/finish/results) and the
//   single-port RAM port of memset_engine.
//
//   modport slave  : the engine side (takes job requests, drives the RAM port)
//   modport master : the requester / memory side (issues jobs, returns read data)
//
//   Signals:
//     start, m, c, n, incr          job request and parameters
//     busy, finish, return_val      job status and result
//     error, error_count            read-back verification result
//     memory_controller_address     RAM address
//     memory_controller_write_enable RAM write strobe
//     memory_controller_in          RAM write data
//     memory_controller_out         RAM read data (one cycle after address)
// -----------------------------------------------------------------------------
interface memset_engine_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] c;
    logic [LEN_WIDTH-1:0]  n;
    logic                  incr;
    logic                  busy;
    logic                  finish;
    logic [ADDR_WIDTH-1:0] return_val;
    logic                  error;
    logic [LEN_WIDTH-1:0]  error_count;
    logic [ADDR_WIDTH-1:0] memory_controller_address;
    logic                  memory_controller_write_enable;
    logic [DATA_WIDTH-1:0] memory_controller_in;
    logic [DATA_WIDTH-1:0] memory_controller_out;

    modport slave (
        input  start, m, c, n, incr, memory_controller_out,
        output busy, finish, return_val, error, error_count,
        output memory_controller_address, memory_controller_write_enable,
        output memory_controller_in
    );

    modport master (
        output start, m, c, n, incr, memory_controller_out,
        input  busy, finish, return_val, error, error_count,
        input  memory_controller_address, memory_controller_write_enable,
        input  memory_controller_in
    );
endinterface

// File: rtl/memset_engine.sv
// -----------------------------------------------------------------------------
// memset_engine
//   Fills a contiguous (wrapping) region of a single-port RAM with either a
//   constant word or an incrementing pattern, one access per cycle, and
//   reports completion with a one-cycle finish pulse.
//
//   Optional feature macro: MEMSET_ENGINE_VERIFY_EN
//     defined     : after the fill, the region is read back and compared;
//                   error / error_count report the number of mismatches.
//     not defined : fill goes straight to completion; error and error_count
//                   are tied to zero and the RAM read data is ignored.
//
//   Ports:
//     clk    single clock, all state on the rising edge
//     reset  asynchronous, active-low; clears all state immediately
//     bus    memset_engine_if.slave: job handshake + RAM port
//
//   All RAM-port outputs and status outputs are registered. busy rises on the
//   accept edge and falls after the finish cycle, so a held start sees at
//   least one cycle with busy low before the next job is accepted.
// -----------------------------------------------------------------------------
module memset_engine #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic            clk,
    input  logic            reset,
    memset_engine_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        VERIFY = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Requested lengths beyond the RAM size clamp to one full pass, so no
    // address is written twice.
    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] req);
        if (LEN_WIDTH > ADDR_WIDTH && req > LEN_WIDTH'(DEPTH)) begin
            return LEN_WIDTH'(DEPTH);
        end
        return req;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_at(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [LEN_WIDTH-1:0]  i);
        // Truncation to ADDR_WIDTH gives the modulo-DEPTH wrap.
        return base + ADDR_WIDTH'(i);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] word_at(input logic [DATA_WIDTH-1:0] base,
                                                      input logic                  inc,
                                                      input logic [LEN_WIDTH-1:0]  i);
        return inc ? base + DATA_WIDTH'(i) : base;
    endfunction

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;     // index of the next word to issue
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic                  incr_q, incr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  finish_q, finish_d;
    logic [ADDR_WIDTH-1:0] ret_q, ret_d;

`ifdef MEMSET_ENGINE_VERIFY_EN
    // rd_*: a read is on the RAM port this cycle with its expected word.
    // chk_*: that read's data is on memory_controller_out this cycle.
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;
    logic                  chk_vld_q, chk_vld_d;
    logic [DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  err_cnt_q, err_cnt_d;
`else
    logic [DATA_WIDTH-1:0] unused_mc_out;
    assign unused_mc_out = bus.memory_controller_out;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        m_d      = m_q;
        c_d      = c_q;
        incr_d   = incr_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        din_d    = din_q;
        busy_d   = busy_q;
        finish_d = 1'b0;
        ret_d    = ret_q;
`ifdef MEMSET_ENGINE_VERIFY_EN
        rd_vld_d  = 1'b0;
        rd_exp_d  = rd_exp_q;
        chk_vld_d = rd_vld_q;
        chk_exp_d = rd_exp_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (chk_vld_q && (bus.memory_controller_out != chk_exp_q)) begin
            err_cnt_d = err_cnt_q + LEN_WIDTH'(1);
        end
`endif

        // busy covers the finish cycle, then drops for at least one cycle.
        if (finish_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !busy_q) begin
                    m_d    = bus.m;
                    c_d    = bus.c;
                    incr_d = bus.incr;
                    len_d  = sat_len(bus.n);
                    busy_d = 1'b1;
`ifdef MEMSET_ENGINE_VERIFY_EN
                    err_d     = 1'b0;
                    err_cnt_d = '0;
`endif
                    if (bus.n == '0) begin
                        state_d = DONE;
                    end else begin
                        // Word 0 goes out on the accept edge itself.
                        state_d = FILL;
                        addr_d  = bus.m;
                        din_d   = bus.c;
                        we_d    = 1'b1;
                        idx_d   = LEN_WIDTH'(1);
                    end
                end
            end

            FILL: begin
                if (idx_q < len_q) begin
                    addr_d = addr_at(m_q, idx_q);
                    din_d  = word_at(c_q, incr_q, idx_q);
                    we_d   = 1'b1;
                    idx_d  = idx_q + LEN_WIDTH'(1);
                end else begin
`ifdef MEMSET_ENGINE_VERIFY_EN
                    state_d  = VERIFY;
                    addr_d   = m_q;
                    rd_vld_d = 1'b1;
                    rd_exp_d = c_q;
                    idx_d    = LEN_WIDTH'(1);
`else
                    state_d = DONE;
`endif
                end
            end

`ifdef MEMSET_ENGINE_VERIFY_EN
            VERIFY: begin
                if (idx_q < len_q) begin
                    addr_d   = addr_at(m_q, idx_q);
                    rd_vld_d = 1'b1;
                    rd_exp_d = word_at(c_q, incr_q, idx_q);
                    idx_d    = idx_q + LEN_WIDTH'(1);
                end else begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                state_d = DONE;
            end
`endif

            DONE: begin
                state_d  = IDLE;
                finish_d = 1'b1;
                ret_d    = m_q;
`ifdef MEMSET_ENGINE_VERIFY_EN
                err_d    = (err_cnt_q != '0);
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            m_q      <= '0;
            c_q      <= '0;
            incr_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            m_q      <= m_d;
            c_q      <= c_d;
            incr_q   <= incr_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            ret_q    <= ret_d;
        end
    end

`ifdef MEMSET_ENGINE_VERIFY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_q  <= 1'b0;
            rd_exp_q  <= '0;
            chk_vld_q <= 1'b0;
            chk_exp_q <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_exp_q  <= rd_exp_d;
            chk_vld_q <= chk_vld_d;
            chk_exp_q <= chk_exp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.error       = err_q;
    assign bus.error_count = err_cnt_q;
`else
    assign bus.error       = 1'b0;
    assign bus.error_count = '0;
`endif

    assign bus.busy                           = busy_q;
    assign bus.finish                         = finish_q;
    assign bus.return_val                     = ret_q;
    assign bus.memory_controller_address      = addr_q;
    assign bus.memory_controller_write_enable = we_q;
    assign bus.memory_controller_in           = din_q;

endmodule

// File: tb/tb_memset_engine.sv
// -----------------------------------------------------------------------------
// tb_memset_engine
//   Drives fill jobs into memset_engine against a behavioural RAM. Each accepted
//   job pushes its expected write sequence and completion record into queues;
//   an independent monitor pops and compares on every write strobe and finish.
// -----------------------------------------------------------------------------
module tb_memset_engine;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int LW    = 6;
    localparam int DEPTH = 32;
`ifdef MEMSET_ENGINE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memset_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    memset_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port RAM with 1-cycle read latency and optional
    // read-data corruption per address.
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] shadow  [DEPTH];
    bit            corrupt [DEPTH];
    logic [DW-1:0] rd_q;
    logic [AW-1:0] rd_addr_q;

    always @(posedge clk) begin
        if (bus.memory_controller_write_enable === 1'b1)
            ram[bus.memory_controller_address] <= bus.memory_controller_in;
        rd_q      <= ram[bus.memory_controller_address];
        rd_addr_q <= bus.memory_controller_address;
    end
    assign bus.memory_controller_out = corrupt[rd_addr_q] ? ~rd_q : rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int ret; int fin_edge; int errc; } res_t;
    wr_t  wq[$];
    res_t rq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int last_fin_edge = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a job should do, from the fill rules alone.
    task automatic push_model(input int m_i, input int c_i, input int n_i, input bit inc_i,
                              input int acc, input int commit);
        int   len, cnt, a, d, errs;
        wr_t  w;
        res_t r;
        len  = (n_i > DEPTH) ? DEPTH : n_i;
        cnt  = (commit >= 0) ? commit : len;
        errs = 0;
        for (int i = 0; i < len; i++) begin
            a = (m_i + i) % DEPTH;
            d = inc_i ? (c_i + i) % (1 << DW) : c_i;
            if (i < cnt) begin
                w.addr = a;
                w.data = d;
                wq.push_back(w);
                shadow[a] = DW'(d);
            end
            if (corrupt[a]) errs++;
        end
        if (commit < 0) begin
            r.ret      = m_i;
            r.fin_edge = acc + ((len == 0) ? 1 : (VERIFY ? 2 * len + 2 : len + 1));
            r.errc     = VERIFY ? errs : 0;
            rq.push_back(r);
        end
    endtask

    task automatic issue(input int m_i, input int c_i, input int n_i, input bit inc_i,
                         input bit hold, input int commit, output int acc);
        logic b;
        bit   got;
        got = 1'b0;
        acc = -1;
        @(negedge clk);
        bus.m     = AW'(m_i);
        bus.c     = DW'(c_i);
        bus.n     = LW'(n_i);
        bus.incr  = inc_i;
        bus.start = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            b = bus.busy;
            @(posedge clk);
            #1;
            if (!b && bus.busy === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (got) begin
            acc = cyc;
            push_model(m_i, c_i, n_i, inc_i, acc, commit);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: busy=%0b, required a job accept within 200 cycles", bus.busy);
        end
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b, required busy low within 300 cycles", bus.busy);
        end
    endtask

    // Monitor: every write strobe and every finish pulse is matched to the model.
    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        int   mm;
        if (rst_n) begin
            if (bus.memory_controller_write_enable === 1'b1) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%0d data=%0d, required no write",
                             bus.memory_controller_address, bus.memory_controller_in);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 64'(bus.memory_controller_address), 64'(w.addr));
                    check("wr_data", 64'(bus.memory_controller_in), 64'(w.data));
                end
            end
            if (bus.finish === 1'b1) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_finish: finish=1, required no pending job");
                end else begin
                    r = rq.pop_front();
                    check("return_val",     64'(bus.return_val), 64'(r.ret));
                    check("finish_edge",    64'(cyc), 64'(r.fin_edge));
                    check("error",          64'(bus.error), 64'(r.errc != 0));
                    check("error_count",    64'(bus.error_count), 64'(r.errc));
                    check("busy_at_finish", 64'(bus.busy), 64'(1));
                    mm = 0;
                    for (int i = 0; i < DEPTH; i++) if (ram[i] !== shadow[i]) mm++;
                    check("ram_words_wrong", 64'(mm), 64'(0));
                end
                last_fin_edge = cyc;
            end
        end
    end

    initial begin
        int acc, acc2;
        logic [DW-1:0] v;
        bus.start = 1'b0;
        bus.m     = '0;
        bus.c     = '0;
        bus.n     = '0;
        bus.incr  = 1'b0;
        rd_q      <= '0;
        rd_addr_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
            v          = DW'($urandom);
            ram[i]    <= v;
            shadow[i]  = v;
            corrupt[i] = 1'b0;
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   64'(bus.busy), 64'(0));
        check("rst_finish", 64'(bus.finish), 64'(0));
        check("rst_ret",    64'(bus.return_val), 64'(0));
        check("rst_error",  64'(bus.error), 64'(0));
        check("rst_errcnt", 64'(bus.error_count), 64'(0));
        check("rst_addr",   64'(bus.memory_controller_address), 64'(0));
        check("rst_we",     64'(bus.memory_controller_write_enable), 64'(0));
        check("rst_in",     64'(bus.memory_controller_in), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Constant fill, incrementing wrap, saturation, zero length.
        issue(4, 'hA5, 8, 1'b0, 1'b0, -1, acc);   wait_idle();
        issue(30, 'hFE, 4, 1'b1, 1'b0, -1, acc);  wait_idle();
        issue(7, 'h11, 40, 1'b1, 1'b0, -1, acc);  wait_idle();
        issue(9, 'h22, 0, 1'b0, 1'b0, -1, acc);   wait_idle();

        // Read-back with corrupted words at 5 and 9, then clean.
        corrupt[5] = 1'b1;
        corrupt[9] = 1'b1;
        issue(0, 'h3C, 16, 1'b0, 1'b0, -1, acc);  wait_idle();
        corrupt[5] = 1'b0;
        corrupt[9] = 1'b0;
        issue(0, 'h3C, 16, 1'b1, 1'b0, -1, acc);  wait_idle();

        // A start pulse while busy must be ignored.
        issue(10, 'h5A, 12, 1'b1, 1'b0, -1, acc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = 5'd3;
        bus.n     = 6'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Held start: second job accepted after exactly one idle cycle.
        issue(20, 'h80, 6, 1'b0, 1'b1, -1, acc);
        issue(20, 'h80, 6, 1'b0, 1'b0, -1, acc2);
        check("held_restart_edge", 64'(acc2), 64'(last_fin_edge + 2));
        wait_idle();

        // Reset during the third fill cycle: two words committed, then abort.
        issue(12, 'h40, 10, 1'b1, 1'b0, 2, acc);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we",     64'(bus.memory_controller_write_enable), 64'(0));
        check("abort_busy",   64'(bus.busy), 64'(0));
        check("abort_finish", 64'(bus.finish), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_abort_busy", 64'(bus.busy), 64'(0));
        issue(12, 'h40, 10, 1'b1, 1'b0, -1, acc); wait_idle();

        // Randomised jobs.
        repeat (20) begin
            for (int i = 0; i < DEPTH; i++) corrupt[i] = VERIFY && ($urandom_range(0, 7) == 0);
            issue(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 1'b0, -1, acc);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("writes_outstanding", 64'(wq.size()), 64'(0));
        check("jobs_outstanding",   64'(rq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memset_engine.md
# memset_engine

Parametrised fill engine that writes a constant or incrementing pattern into a contiguous region of a single-port RAM, with start/finish handshake. Drives the RAM port of a memory controller directly (one access per cycle, 1-cycle read latency) and replaces the fixed-width 32×8 memset datapath with configurable address/data widths, wrap-around addressing, pattern mode and optional read-back verification.

## Interface
Parameters:
- ADDR_WIDTH, 5, RAM address width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, RAM word width
- LEN_WIDTH, ADDR_WIDTH+1, width of length input and error counter

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately
- start  input  1  request; sampled only in IDLE
- m  input  ADDR_WIDTH  base address
- c  input  DATA_WIDTH  fill value (first value in incrementing mode)
- n  input  LEN_WIDTH  word count
- incr  input  1  0: constant c; 1: word i gets c+i
- busy  output  1  high from accept until finish cycle inclusive
- finish  output  1  one-cycle completion pulse
- return_val  output  ADDR_WIDTH  latched m, valid from finish until next accept
- memory_controller_address  output  ADDR_WIDTH  RAM address
- memory_controller_write_enable  output  1  RAM write strobe
- memory_controller_in  output  DATA_WIDTH  RAM write data
- memory_controller_out  input  DATA_WIDTH  RAM read data, valid one cycle after address
- error  output  1  verify mismatch flag, valid with finish
- error_count  output  LEN_WIDTH  mismatch count, valid with finish

## Operation
- States: IDLE, FILL, VERIFY, DRAIN, DONE.
- IDLE: start=1 latches m, c, incr, and len = min(n, DEPTH); clears error_count; busy=1. Next state FILL, or DONE if n==0 (no RAM access).
- FILL: one write per cycle; word i (0..len-1): address = (m+i) mod DEPTH, data = incr ? (c+i) mod 2**DATA_WIDTH : c, write_enable=1. After word len-1: VERIFY if compiled in, else DONE.
- VERIFY: one read per cycle, same address sequence, write_enable=0; read data is compared one cycle later against the expected word; mismatch increments error_count. After last address issued: DRAIN.
- DRAIN: compares final read word, no RAM access; then DONE.
- DONE: finish=1, busy=1, return_val=m, error = (error_count != 0); next state IDLE.
- start outside IDLE is ignored (no queueing). start held high re-triggers from the cycle after DONE.
- All RAM-port outputs are registered; outside FILL/VERIFY: write_enable=0, address and data hold their last value.
- n > DEPTH saturates to DEPTH: each address written exactly once; no overwrite on wrap.
- Address wrap: m=DEPTH-1, n=2 writes DEPTH-1 then 0.
- Reset mid-operation: abort instantly, write_enable=0, no finish pulse, state IDLE.

## Timing
- Reset values: busy=0, finish=0, return_val=0, error=0, error_count=0, address=0, write_enable=0, in=0; state IDLE.
- Start accepted at edge k -> first write presented in cycle after edge k (write committed by RAM at edge k+1).
- Without verify: finish high in cycle after edge k+len+1 latency = len+1 cycles from accept edge to finish rising.
- With verify: finish latency = 2·len+2 cycles.
- n==0: finish in cycle after edge k+1 (FILL skipped).
- Back-to-back: earliest next accept is the edge ending the DONE cycle+1 (IDLE for ≥1 cycle).

## Configuration
- MEMSET_ENGINE_VERIFY_EN defined: VERIFY and DRAIN states exist; error/error_count reflect read-back mismatches.
- Not defined: FILL goes straight to DONE; VERIFY/DRAIN logic absent; error and error_count tied 0; memory_controller_out unused except kept connected.

## Test plan
- Constant fill: ADDR_WIDTH=5, DATA_WIDTH=8, m=4, c=0xA5, n=8, incr=0 -> addresses 4..11 written 0xA5, finish after 9 cycles (no verify), return_val=4, RAM words 3 and 12 unchanged.
- Incrementing wrap: m=30, c=0xFE, n=4, incr=1 -> writes 30:0xFE, 31:0xFF, 0:0x00, 1:0x01.
- Saturation/zero: n=40 -> exactly 32 writes, all addresses once; n=0 -> no write_enable, finish 1 cycle after accept.
- Verify (macro on): fill m=0, n=16, c=0x3C with bench corrupting read data at addresses 5 and 9 -> error=1, error_count=2, finish latency 34; uncorrupted run -> error=0.
- Handshake: start pulsed during FILL ignored; start held high -> second job begins one IDLE cycle after finish.
- Reset abort: reset low at 3rd FILL cycle -> write_enable drops immediately, busy=0, no finish; new start after release runs normally.
